wt_mem_arbiter: RTL

WT_MEM_ARBITER -- requirements
Module: wt_mem_arbiter

---
 rtl/wt_mem_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/wt_mem_arbiter.sv
// Wavetable memory arbiter: one loader writer and NV round-robin voice readers
// share a single-transaction memory controller port.
//   state   | meaning
//   S_IDLE  | pick a winner, latch its address/data
//   S_ISSUE | one-cycle RD or WR strobe
//   S_WAIT  | wait for Done or abort after TIMEOUT cycles
//   S_RESP  | one-cycle ack to the granted requester
module wt_mem_arbiter #(
  parameter int NV      = 4,
  parameter int AW      = 15,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NV-1:0]      i_v_req,
  input  logic [NV*AW-1:0]   i_v_addr,
  input  logic               i_ld_req,
  input  logic [AW-1:0]      i_ld_addr,
  input  logic [DW-1:0]      i_ld_wdata,
  output logic [NV-1:0]      o_v_ack,
  output logic [DW-1:0]      o_v_data,
  output logic               o_ld_ack,
  output logic [AW-1:0]      o_mem_addr,
  output logic [DW-1:0]      o_mem_wdata,
  output logic               o_mem_rd,
  output logic               o_mem_wr,
  input  logic [DW-1:0]      i_mem_rdata,
  input  logic               i_mem_done,
  output logic               o_busy,
  output logic               o_timeout_err
);

  localparam int PW = (NV > 1) ? $clog2(NV) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [DW-1:0]   r_v_data;
  logic [NV-1:0]   r_v_ack;
  logic            r_ld_ack;
  logic            r_mem_rd;
  logic            r_mem_wr;
  logic            r_busy;
  logic            r_timeout_err;
  logic [PW-1:0]   r_rr_ptr;
  logic [1:0]      r_ld_streak;
  logic [CW-1:0]   r_wait_cnt;
  logic            r_gnt_ld;
  logic [PW-1:0]   r_gnt_id;

  logic            w_v_any;
  logic            w_ld_win;
  logic            w_v_found;
  logic [PW-1:0]   w_v_win;
  logic [PW-1:0]   w_rr_next;

  assign w_v_any  = |i_v_req;
  // Two loader grants in a row hand the next slot to a waiting voice.
  assign w_ld_win = i_ld_req && !((r_ld_streak == 2'd2) && w_v_any);

  always_comb begin : rr_search
    int idx;
    w_v_found = 1'b0;
    w_v_win   = '0;
    idx       = 0;
    for (int k = 0; k < NV; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NV) idx = idx - NV;
      if (!w_v_found && i_v_req[idx]) begin
        w_v_found = 1'b1;
        w_v_win   = PW'(idx);
      end
    end
  end

  assign w_rr_next = (w_v_win == PW'(NV - 1)) ? '0 : w_v_win + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_v_data      <= '0;
      r_v_ack       <= '0;
      r_ld_ack      <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_rr_ptr      <= '0;
      r_ld_streak   <= '0;
      r_wait_cnt    <= '0;
      r_gnt_ld      <= 1'b0;
      r_gnt_id      <= '0;
    end else begin
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_v_ack  <= '0;
      r_ld_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_ld_req || w_v_any) begin
            r_state <= S_ISSUE;
            r_busy  <= 1'b1;
            if (w_ld_win) begin
              r_gnt_ld    <= 1'b1;
              r_mem_addr  <= i_ld_addr;
              r_mem_wdata <= i_ld_wdata;
              if (r_ld_streak != 2'd2) r_ld_streak <= r_ld_streak + 2'd1;
            end else begin
              r_gnt_ld    <= 1'b0;
              r_gnt_id    <= w_v_win;
              r_mem_addr  <= i_v_addr[w_v_win*AW +: AW];
              r_rr_ptr    <= w_rr_next;
              r_ld_streak <= '0;
            end
          end
        end
        S_ISSUE: begin
          r_mem_rd <= !r_gnt_ld;
          r_mem_wr <= r_gnt_ld;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (i_mem_done) begin
            if (!r_gnt_ld) r_v_data <= i_mem_rdata;
            if (r_gnt_ld) r_ld_ack <= 1'b1;
            else          r_v_ack  <= NV'(1) << r_gnt_id;
            r_state <= S_RESP;
          end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
            r_timeout_err <= 1'b1;
            if (!r_gnt_ld) r_v_data <= '0;
            if (r_gnt_ld) r_ld_ack <= 1'b1;
            else          r_v_ack  <= NV'(1) << r_gnt_id;
            r_state <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_wait_cnt <= '0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_v_ack       = r_v_ack;
  assign o_v_data      = r_v_data;
  assign o_ld_ack      = r_ld_ack;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_mem_rd      = r_mem_rd;
  assign o_mem_wr      = r_mem_wr;
  assign o_busy        = r_busy;
  assign o_timeout_err = r_timeout_err;

endmodule
